cache_assoc: RTL and testbench
==============================

// Module: cache_assoc
// PURPOSE
//  Parametrised N-way set-associative cache storage array (tags, valid/dirty, data, replacement state) for the memory stage.
//  Generalises the direct-mapped array: WAYS ways per set, true-LRU victim selection, and a built-in flush engine.
//  The flush engine walks every line and hands dirty lines to the memory controller over a valid/ready writeback port.
// PARAMETERS
//  WORD_BITS        32  data word width
//  ADDR_BITS        32  byte address width
//  WORD_BYTES_WIDTH 2   log2(bytes per word)
//  LINE_WORDS_WIDTH 2   log2(words per line); line holds 2**LINE_WORDS_WIDTH words
//  SET_INDEX_WIDTH  5   log2(number of sets)
//  WAY_WIDTH        1   log2(WAYS); WAYS = 2**WAY_WIDTH, 1..8 ways supported
//  TAG_BITS (local)     ADDR_BITS-SET_INDEX_WIDTH-LINE_WORDS_WIDTH-WORD_BYTES_WIDTH
// PORTS
//  clk        in  1                clock, rising edge
//  rst        in  1                asynchronous active-high reset
//  addr       in  ADDR_BITS        access address: tag | set | word | byte
//  store      in  1                fill word; sets valid=1, dirty=0, tag=addr tag
//  edit       in  1                CPU write of word into hit way; sets dirty=1
//  invalid    in  1                clear valid of hit way
//  touch      in  1                read access; updates LRU on hit
//  din        in  WORD_BITS        write data
//  hit        out 1                addr tag matches a valid way in set
//  hit_way    out WAY_WIDTH        index of matching way (0 when no hit)
//  dout       out WORD_BITS        word from hit way, else from victim way
//  valid      out 1                victim way valid
//  dirty      out 1                victim way dirty
//  tag        out TAG_BITS         victim way tag (writeback address formation)
//  flush_req  in  1                start flush of whole cache
//  flush_busy out 1                flush engine active
//  flush_done out 1                one-cycle pulse at flush completion
//  wb_valid   out 1                dirty line offered for writeback
//  wb_ready   in  1                controller accepts wb line
//  wb_addr    out ADDR_BITS        line base address {tag,set,0}
//  wb_way     out WAY_WIDTH        way of offered line (controller reads words via dout)
// BEHAVIOUR
//  - Reads combinational from addr. Writes happen at posedge clk and are visible in the next cycle.
//  - Write way: store uses hit_way if hit, else the victim. edit, invalid and touch act only on hit; they are ignored on a miss.
//  - Priority when several strobes are high: invalid > store > edit > touch. Data is written on store/edit only.
//  - Victim: lowest-index invalid way. If all ways are valid, the way whose age == WAYS-1.
//  - LRU: per set, per way, a WAY_WIDTH-bit age; the ages in a set always form a permutation of 0..WAYS-1.
//    On store/edit/touch to way w: age[w] <= 0, and every way with age < old age[w] increments. invalid leaves ages unchanged.
//  - Reset (async): all valid=0, dirty=0, age[w]=w in every set, FSM IDLE, flush_done=0, wb_valid=0, flush_busy=0.
//    Tag and data arrays are not reset.
//  - FSM states IDLE, SCAN, WB, DONE; cursor {set,way} starts at 0.
//    IDLE: flush_req -> SCAN, cursor=0.
//    SCAN: one cycle per line. valid&dirty -> WB. Otherwise clear valid; if cursor is the last line -> DONE, else cursor++.
//    WB: wb_valid=1, wb_addr/wb_way stable. On wb_valid&wb_ready: clear valid and dirty, then last line -> DONE, else cursor++ and -> SCAN.
//    DONE: flush_done=1 for one cycle -> IDLE.
//  - While flush_busy (SCAN/WB/DONE):
//    - hit forced 0; store/edit/invalid/touch ignored.
//    - dout, valid, dirty and tag address the cursor line.
//    - flush_req ignored.
//  - Reset mid-flush aborts immediately; no further wb_valid. Lines not yet written back are lost (valid=0).
//  - Flush latency with no dirty lines: 2**SET_INDEX_WIDTH * WAYS SCAN cycles + 1 DONE cycle.
// TESTING
//  1. Reset; addr=0x10 -> hit=0, valid=0. store din=0xA5A5A5A5 @0x10; next cycle hit=1, hit_way=0, dout=0xA5A5A5A5, dirty=0.
//  2. Fill @0x10 (way0) then @0x210 (way1). Touch 0x10, then store @0x410 -> lands in way1; 0x210 misses; 0x10 still hits.
//  3. Hit @0x10 + edit din=0x1 -> dirty=1, dout=0x1. Miss @0x810 with victim way0 -> valid=1, dirty=1, tag=0x0.
//  4. Set 1 way0 dirty; flush_req, wb_ready=0 -> wb_valid=1 with wb_addr=0x10, held 5 cycles. wb_ready=1 -> accepted;
//     flush_done pulses after 64 lines scanned; all lookups miss.
//  5. invalid + store same cycle on a hit -> line invalid, tag unchanged. Assert rst during WB -> wb_valid=0 and flush_busy=0
//     asynchronously; all misses.

Source files
------------

// File: rtl/cache_assoc.sv
// rtl/cache_assoc.sv - N-way set-associative cache storage array with true-LRU and flush engine
//
// Holds tags, valid/dirty bits, line data and per-way LRU ages for every set.
// Lookups are combinational from addr; writes land on the rising clock edge.
// The flush engine walks every {set,way} line and hands dirty lines to the
// memory controller over a valid/ready writeback port.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   addr                access address: tag | set | word | byte
//   store/edit/invalid/touch  access strobes (priority invalid > store > edit > touch)
//   din                 write data for store/edit
//   hit, hit_way        lookup result (hit_way is 0 on a miss)
//   dout                word from the hit way, else from the victim (cursor line while flushing)
//   valid, dirty, tag   state of the victim way (cursor line while flushing)
//   flush_req           start a whole-cache flush
//   flush_busy          flush engine active
//   flush_done          one-cycle pulse when the flush completes
//   wb_valid, wb_ready  writeback handshake for a dirty line
//   wb_addr, wb_way     line base address and way of the offered line
module cache_assoc #(
  parameter int WORD_BITS        = 32,
  parameter int ADDR_BITS        = 32,
  parameter int WORD_BYTES_WIDTH = 2,
  parameter int LINE_WORDS_WIDTH = 2,
  parameter int SET_INDEX_WIDTH  = 5,
  parameter int WAY_WIDTH        = 1,
  localparam int TAG_BITS = ADDR_BITS - SET_INDEX_WIDTH - LINE_WORDS_WIDTH - WORD_BYTES_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 store,
  input  logic                 edit,
  input  logic                 invalid,
  input  logic                 touch,
  input  logic [WORD_BITS-1:0] din,
  output logic                 hit,
  output logic [WAY_WIDTH-1:0] hit_way,
  output logic [WORD_BITS-1:0] dout,
  output logic                 valid,
  output logic                 dirty,
  output logic [TAG_BITS-1:0]  tag,
  input  logic                 flush_req,
  output logic                 flush_busy,
  output logic                 flush_done,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [ADDR_BITS-1:0] wb_addr,
  output logic [WAY_WIDTH-1:0] wb_way
);

  localparam int WAYS       = 1 << WAY_WIDTH;
  localparam int SETS       = 1 << SET_INDEX_WIDTH;
  localparam int LINE_WORDS = 1 << LINE_WORDS_WIDTH;
  localparam int OFF_BITS   = LINE_WORDS_WIDTH + WORD_BYTES_WIDTH;
  localparam int CUR_BITS   = SET_INDEX_WIDTH + WAY_WIDTH;

  typedef enum logic [1:0] {IDLE, SCAN, WB, DONE} state_t;

  // Storage
  logic [TAG_BITS-1:0]                 tag_q   [SETS][WAYS];
  logic [WORD_BITS-1:0]                data_q  [SETS][WAYS][LINE_WORDS];
  logic [WAYS-1:0]                     valid_q [SETS];
  logic [WAYS-1:0]                     dirty_q [SETS];
  logic [WAYS-1:0][WAY_WIDTH-1:0]      age_q   [SETS];

  state_t              state_q, state_d;
  logic [CUR_BITS-1:0] cur_q, cur_d;

  // Address decode
  logic [TAG_BITS-1:0]         addr_tag;
  logic [SET_INDEX_WIDTH-1:0]  set_idx;
  logic [LINE_WORDS_WIDTH-1:0] word_idx;
  logic                        byte_offset_unused;

  assign addr_tag           = addr[ADDR_BITS-1 -: TAG_BITS];
  assign set_idx            = addr[OFF_BITS +: SET_INDEX_WIDTH];
  assign word_idx           = addr[WORD_BYTES_WIDTH +: LINE_WORDS_WIDTH];
  assign byte_offset_unused = ^addr[WORD_BYTES_WIDTH-1:0];

  logic [SET_INDEX_WIDTH-1:0] cur_set;
  logic [WAY_WIDTH-1:0]       cur_way;
  logic                       busy;

  assign cur_set = cur_q[WAY_WIDTH +: SET_INDEX_WIDTH];
  assign cur_way = cur_q[WAY_WIDTH-1:0];
  assign busy    = (state_q != IDLE);

  // Lookup and victim selection
  logic                 hit_raw;
  logic [WAY_WIDTH-1:0] hit_way_raw;
  logic [WAY_WIDTH-1:0] victim;

  always_comb begin
    hit_raw     = 1'b0;
    hit_way_raw = '0;
    victim      = '0;
    // Descending scan so the lowest matching way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[set_idx][w] && (tag_q[set_idx][w] == addr_tag)) begin
        hit_raw     = 1'b1;
        hit_way_raw = WAY_WIDTH'(w);
      end
    end
    // Oldest way first, then overridden by the lowest-index invalid way.
    for (int w = 0; w < WAYS; w++) begin
      if (age_q[set_idx][w] == WAY_WIDTH'(WAYS - 1)) victim = WAY_WIDTH'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[set_idx][w]) victim = WAY_WIDTH'(w);
    end
  end

  // Access decode: CPU strobes are dropped entirely while the flush engine runs.
  logic                 op_inv, op_store, op_edit, op_touch;
  logic [WAY_WIDTH-1:0] op_way;

  assign op_inv   = !busy && invalid && hit_raw;
  assign op_store = !busy && !invalid && store;
  assign op_edit  = !busy && !invalid && !store && edit && hit_raw;
  assign op_touch = !busy && !invalid && !store && !edit && touch && hit_raw;
  assign op_way   = hit_raw ? hit_way_raw : victim;

  // Flush FSM
  logic fl_clr_valid, fl_clr_dirty;
  logic cur_last;

  assign cur_last = (cur_q == {CUR_BITS{1'b1}});

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    fl_clr_valid = 1'b0;
    fl_clr_dirty = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d = SCAN;
          cur_d   = '0;
        end
      end
      SCAN: begin
        if (valid_q[cur_set][cur_way] && dirty_q[cur_set][cur_way]) begin
          state_d = WB;
        end else begin
          fl_clr_valid = 1'b1;
          if (cur_last) state_d = DONE;
          else          cur_d   = cur_q + CUR_BITS'(1);
        end
      end
      WB: begin
        if (wb_ready) begin
          fl_clr_valid = 1'b1;
          fl_clr_dirty = 1'b1;
          if (cur_last) begin
            state_d = DONE;
          end else begin
            cur_d   = cur_q + CUR_BITS'(1);
            state_d = SCAN;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Line update: CPU accesses and flush clears never coincide, so one target suffices.
  logic [SET_INDEX_WIDTH-1:0]     wr_set;
  logic [WAY_WIDTH-1:0]           wr_way;
  logic                           valid_we, dirty_we, lru_we, data_we;
  logic [WAYS-1:0]                valid_row_d, dirty_row_d;
  logic [WAYS-1:0][WAY_WIDTH-1:0] age_row_d;
  logic [WAY_WIDTH-1:0]           old_age;

  assign wr_set   = busy ? cur_set : set_idx;
  assign wr_way   = busy ? cur_way : op_way;
  assign valid_we = op_inv || op_store || fl_clr_valid;
  assign dirty_we = op_store || op_edit || fl_clr_dirty;
  assign lru_we   = op_store || op_edit || op_touch;
  assign data_we  = op_store || op_edit;
  assign old_age  = age_q[wr_set][wr_way];

  always_comb begin
    valid_row_d         = valid_q[wr_set];
    valid_row_d[wr_way] = op_store;
    dirty_row_d         = dirty_q[wr_set];
    dirty_row_d[wr_way] = op_edit;
    age_row_d           = age_q[wr_set];
    // Ways younger than the accessed one age by one; the accessed way becomes youngest.
    for (int w = 0; w < WAYS; w++) begin
      if (age_q[wr_set][w] < old_age) age_row_d[w] = age_q[wr_set][w] + WAY_WIDTH'(1);
    end
    age_row_d[wr_way] = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= WAY_WIDTH'(w);
      end
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      if (valid_we) valid_q[wr_set] <= valid_row_d;
      if (dirty_we) dirty_q[wr_set] <= dirty_row_d;
      if (lru_we)   age_q[wr_set]   <= age_row_d;
    end
  end

  // Tag and data arrays carry no reset.
  always_ff @(posedge clk) begin
    if (op_store) tag_q[wr_set][wr_way] <= addr_tag;
    if (data_we)  data_q[wr_set][wr_way][word_idx] <= din;
  end

  // Outputs: while flushing, the status/data outputs follow the cursor line.
  logic [SET_INDEX_WIDTH-1:0] rd_set;
  logic [WAY_WIDTH-1:0]       rd_way;
  logic [WAY_WIDTH-1:0]       dout_way;

  assign rd_set   = busy ? cur_set : set_idx;
  assign rd_way   = busy ? cur_way : victim;
  assign dout_way = busy ? cur_way : op_way;

  assign hit        = hit_raw && !busy;
  assign hit_way    = hit ? hit_way_raw : '0;
  assign dout       = data_q[rd_set][dout_way][word_idx];
  assign valid      = valid_q[rd_set][rd_way];
  assign dirty      = dirty_q[rd_set][rd_way];
  assign tag        = tag_q[rd_set][rd_way];
  assign flush_busy = busy;
  assign flush_done = (state_q == DONE);
  assign wb_valid   = (state_q == WB);
  assign wb_addr    = {tag_q[cur_set][cur_way], cur_set, {OFF_BITS{1'b0}}};
  assign wb_way     = cur_way;

endmodule

// File: tb/tb_cache_assoc.sv
// tb/tb_cache_assoc.sv - scoreboard bench for cache_assoc (2 ways, 32 sets, 4-word lines)
module tb_cache_assoc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0;
  logic        store = 1'b0, edit = 1'b0, invalid = 1'b0, touch = 1'b0;
  logic [31:0] din = '0;
  logic        hit;
  logic [0:0]  hit_way;
  logic [31:0] dout;
  logic        valid, dirty;
  logic [22:0] tag;
  logic        flush_req = 1'b0;
  logic        flush_busy, flush_done;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [31:0] wb_addr;
  logic [0:0]  wb_way;

  always #5 clk = ~clk;

  cache_assoc dut (
    .clk(clk), .rst(rst), .addr(addr), .store(store), .edit(edit), .invalid(invalid),
    .touch(touch), .din(din), .hit(hit), .hit_way(hit_way), .dout(dout), .valid(valid),
    .dirty(dirty), .tag(tag), .flush_req(flush_req), .flush_busy(flush_busy),
    .flush_done(flush_done), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
    .wb_way(wb_way)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          test_no  = 0;
  string       exp_field_q[$];
  logic [31:0] exp_val_q[$];
  logic [31:0] wb_exp_q[$];

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input string f);
    case (f)
      "hit":     return {31'b0, hit};
      "hit_way": return {31'b0, hit_way};
      "dout":    return dout;
      "valid":   return {31'b0, valid};
      "dirty":   return {31'b0, dirty};
      "tag":     return {9'b0, tag};
      "busy":    return {31'b0, flush_busy};
      "done":    return {31'b0, flush_done};
      "wbv":     return {31'b0, wb_valid};
      "wb_addr": return wb_addr;
      "wb_way":  return {31'b0, wb_way};
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_out(input string f, input logic [31:0] v);
    exp_field_q.push_back(f);
    exp_val_q.push_back(v);
  endtask

  task automatic compare_pending();
    string       f;
    logic [31:0] v;
    while (exp_field_q.size() > 0) begin
      f = exp_field_q.pop_front();
      v = exp_val_q.pop_front();
      check($sformatf("t%0d_%s", test_no, f), observe(f), v);
    end
  endtask

  task automatic clear_strobes();
    store = 1'b0; edit = 1'b0; invalid = 1'b0; touch = 1'b0; flush_req = 1'b0;
  endtask

  task automatic access(input logic [31:0] a, input logic s, input logic e, input logic i,
                        input logic t, input logic [31:0] d);
    addr = a; store = s; edit = e; invalid = i; touch = t; din = d;
    @(posedge clk); #1;
    clear_strobes();
  endtask

  task automatic look(input logic [31:0] a);
    addr = a;
    @(negedge clk);
  endtask

  task automatic wait_wb(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (wb_valid) seen = 1'b1;
    end
  endtask

  task automatic check_wb_addr(input string name);
    if (wb_exp_q.size() == 0) check({name, "_sb_underflow"}, 32'd0, 32'd1);
    else                      check(name, wb_addr, wb_exp_q.pop_front());
  endtask

  bit seen;
  int cyc, wb_cnt;

  initial begin
    // Test 1: reset state and a first fill
    test_no = 1;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    look(32'h10);
    expect_out("hit", 0); expect_out("valid", 0); expect_out("busy", 0);
    expect_out("done", 0); expect_out("wbv", 0);
    compare_pending();
    access(32'h10, 1, 0, 0, 0, 32'hA5A5_A5A5);
    look(32'h10);
    expect_out("hit", 1); expect_out("hit_way", 0); expect_out("dout", 32'hA5A5_A5A5);
    expect_out("dirty", 0);
    compare_pending();

    // Test 2: LRU replacement within set 1
    test_no = 2;
    access(32'h210, 1, 0, 0, 0, 32'h1111_1111);
    look(32'h210);
    expect_out("hit", 1); expect_out("hit_way", 1); expect_out("dout", 32'h1111_1111);
    compare_pending();
    access(32'h10, 0, 0, 0, 1, 32'h0);
    access(32'h410, 1, 0, 0, 0, 32'h2222_2222);
    look(32'h410);
    expect_out("hit", 1); expect_out("hit_way", 1); expect_out("dout", 32'h2222_2222);
    compare_pending();
    look(32'h210);
    expect_out("hit", 0);
    compare_pending();
    look(32'h10);
    expect_out("hit", 1); expect_out("hit_way", 0); expect_out("dout", 32'hA5A5_A5A5);
    compare_pending();

    // Test 3: edit marks dirty; misses ignore edit/touch; victim reports way0 state
    test_no = 3;
    access(32'h10, 0, 1, 0, 0, 32'h1);
    wb_exp_q.push_back(32'h10);
    look(32'h10);
    expect_out("hit", 1); expect_out("dout", 32'h1);
    compare_pending();
    access(32'h410, 0, 0, 0, 1, 32'h0);
    access(32'h810, 0, 1, 0, 0, 32'hDEAD);
    access(32'h810, 0, 0, 0, 1, 32'h0);
    look(32'h810);
    expect_out("hit", 0); expect_out("hit_way", 0); expect_out("valid", 1);
    expect_out("dirty", 1); expect_out("tag", 0); expect_out("dout", 32'h1);
    compare_pending();

    // Test 4: flush with a stalled writeback, then a clean flush for latency
    test_no = 4;
    addr = 32'h10;
    wb_ready = 1'b0;
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    wait_wb(seen);
    check("t4_wb_seen", {31'b0, seen}, 32'd1);
    if (seen) begin
      check_wb_addr("t4_wb_addr");
      expect_out("wb_way", 0); expect_out("busy", 1); expect_out("hit", 0);
      expect_out("dout", 32'h1); expect_out("dirty", 1);
      compare_pending();
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        expect_out("wbv", 1); expect_out("wb_addr", 32'h10);
        compare_pending();
      end
      wb_ready = 1'b1;
      @(negedge clk);
      wb_ready = 1'b0;
      expect_out("wbv", 0); expect_out("busy", 1);
      compare_pending();
    end
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (flush_done) seen = 1'b1;
    end
    check("t4_done_seen", {31'b0, seen}, 32'd1);
    @(negedge clk);
    expect_out("busy", 0); expect_out("done", 0);
    compare_pending();
    look(32'h10);  expect_out("hit", 0); expect_out("valid", 0); compare_pending();
    look(32'h410); expect_out("hit", 0); compare_pending();

    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    cyc = 0; wb_cnt = 0; seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (wb_valid) wb_cnt++;
      if (flush_done) seen = 1'b1;
    end
    check("t4_clean_latency", cyc, 65);
    check("t4_clean_wb_count", wb_cnt, 0);

    // Test 5: invalid beats store; reset aborts a pending writeback
    test_no = 5;
    @(negedge clk);
    access(32'h10, 1, 0, 0, 0, 32'h55);
    access(32'h10, 1, 0, 1, 0, 32'h99);
    look(32'h10);
    expect_out("hit", 0); expect_out("valid", 0); expect_out("tag", 0);
    expect_out("dout", 32'h55);
    compare_pending();
    access(32'h10, 1, 0, 0, 0, 32'h66);
    access(32'h10, 0, 1, 0, 0, 32'h7);
    wb_exp_q.push_back(32'h10);
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    wait_wb(seen);
    check("t5_wb_seen", {31'b0, seen}, 32'd1);
    if (seen) check_wb_addr("t5_wb_addr");
    #1 rst = 1'b1;
    #1;
    expect_out("wbv", 0); expect_out("busy", 0);
    compare_pending();
    @(negedge clk);
    rst = 1'b0;
    wb_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (wb_valid) wb_cnt++;
    end
    check("t5_wb_after_rst", wb_cnt, 0);
    look(32'h10);
    expect_out("hit", 0); expect_out("valid", 0); expect_out("dirty", 0);
    compare_pending();

    check("sb_wb_leftover", wb_exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
